// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, issues word requests over a
// req/ack handshake and hands fetched words to decode with stall backpressure.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] SKID  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

  logic [1:0]      state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] req_addr_n;
  logic            imem_req_n;
  logic            instr_valid_n;
  logic [XLEN-1:0] instr_n, instr_pc_n;
  logic [XLEN-1:0] skid_word, skid_word_n;
  logic [XLEN-1:0] skid_addr, skid_addr_n;
  logic            skid_valid, skid_valid_n;

  logic            xfer_c;
  logic            consumed_c;
  logic            slot_free_c;
  logic [XLEN-1:0] pc_inc_c;
  logic [XLEN-1:0] redirect_tgt_c;

  // Handshake and slot-occupancy qualifiers
  always_comb begin
    xfer_c         = imem_req && imem_ack;
    consumed_c     = instr_valid && !stall;
    slot_free_c    = !instr_valid || !stall;
    pc_inc_c       = pc + PC_STEP;
    redirect_tgt_c = redirect_pc & WORD_MASK;
  end

  // State, PC, request address, output slot and skid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC & WORD_MASK;
      imem_addr   <= RESET_PC & WORD_MASK;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      skid_word   <= '0;
      skid_addr   <= '0;
      skid_valid  <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      imem_addr   <= req_addr_n;
      imem_req    <= imem_req_n;
      instr_valid <= instr_valid_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      skid_word   <= skid_word_n;
      skid_addr   <= skid_addr_n;
      skid_valid  <= skid_valid_n;
    end
  end

  // Next-state logic; redirect outranks normal sequencing
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    req_addr_n    = imem_addr;
    instr_valid_n = instr_valid;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    skid_word_n   = skid_word;
    skid_addr_n   = skid_addr;
    skid_valid_n  = skid_valid;

    if (redirect_valid) begin
      instr_valid_n = 1'b0;
      skid_valid_n  = 1'b0;
      pc_n          = redirect_tgt_c;
      case (state)
        REQ: begin
          // An outstanding request cannot be withdrawn, so wait it out in DRAIN
          if (xfer_c) begin
            state_n    = REQ;
            req_addr_n = redirect_tgt_c;
          end else begin
            state_n = DRAIN;
          end
        end
        DRAIN: state_n = DRAIN;
        default: begin
          state_n    = REQ;
          req_addr_n = redirect_tgt_c;
        end
      endcase
    end else begin
      if (consumed_c) begin
        instr_valid_n = 1'b0;
      end
      case (state)
        IDLE: begin
          state_n    = REQ;
          req_addr_n = pc;
        end
        REQ: begin
          if (xfer_c) begin
            pc_n = pc_inc_c;
            if (slot_free_c) begin
              instr_valid_n = 1'b1;
              instr_n       = imem_rdata;
              instr_pc_n    = imem_addr;
              req_addr_n    = pc_inc_c;
            end else begin
              skid_valid_n = 1'b1;
              skid_word_n  = imem_rdata;
              skid_addr_n  = imem_addr;
              state_n      = SKID;
            end
          end
        end
        SKID: begin
          if (slot_free_c) begin
            instr_valid_n = 1'b1;
            instr_n       = skid_word;
            instr_pc_n    = skid_addr;
            skid_valid_n  = 1'b0;
            req_addr_n    = pc;
            state_n       = REQ;
          end
        end
        default: begin
          // DRAIN: the returning word belongs to the abandoned stream
          if (xfer_c) begin
            req_addr_n = pc;
            state_n    = REQ;
          end
        end
      endcase
    end

    imem_req_n = (state_n == REQ) || (state_n == DRAIN);
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus a randomized run
// scored against a stream-level model of the expected instruction sequence.
module tb_fetch_controller;

  localparam logic [31:0] MAGIC = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int checks;
  int failures;

  fetch_controller #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  // Memory content is a fixed function of the word address
  assign imem_rdata = imem_addr ^ MAGIC;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ MAGIC;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; stall = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    rst = 1'b0; stall = 1'b0;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0h exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", instr_valid); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", instr); end
    checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL first_req got=%0h/%h exp=1/0", imem_req, imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL first_req_valid got=%0h exp=0", instr_valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k) || instr !== word_at(32'(4 * k))) begin
        failures++;
        $display("FAIL stream_%0d got=%0h/%h/%h exp=1/%h/%h", k, instr_valid, instr_pc, instr, 32'(4 * k), word_at(32'(4 * k)));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    imem_ack = 1'b1;
    tick(); tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || imem_req !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold_%0d got=%0h/%h/req%0h exp=1/0/req0", k, instr_valid, instr_pc, imem_req);
      end
    end
    stall = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr !== word_at(32'h4)) begin failures++; $display("FAIL skid_release got=%0h/%h/%h exp=1/4/%h", instr_valid, instr_pc, instr, word_at(32'h4)); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL skid_next_req got=%0h/%h exp=1/8", imem_req, imem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin failures++; $display("FAIL after_skid got=%0h/%h exp=1/8", instr_valid, instr_pc); end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    imem_ack = 1'b1;
    tick(); tick(); tick();
    imem_ack = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL drain_pre got=%0h/%h exp=1/8", imem_req, imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL drain_flush got=%0h exp=0", instr_valid); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL drain_hold_%0d got=%0h/%h/v%0h exp=1/8/v0", k, imem_req, imem_addr, instr_valid);
      end
      tick();
    end
    imem_ack = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h100) begin failures++; $display("FAIL drain_done got=%0h/%h exp=0/100", instr_valid, imem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin failures++; $display("FAIL drain_first got=%0h/%h exp=1/100", instr_valid, instr_pc); end
  endtask

  task automatic test_redirect_on_xfer();
    do_reset();
    imem_ack = 1'b1;
    tick(); tick(); tick(); tick();
    checks++; if (imem_addr !== 32'hC) begin failures++; $display("FAIL xfer_pre got=%h exp=c", imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL xfer_redirect got=%0h/%0h/%h exp=0/1/100", instr_valid, imem_req, imem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== word_at(32'h100)) begin failures++; $display("FAIL xfer_first got=%0h/%h exp=1/100", instr_valid, instr_pc); end
  endtask

  task automatic test_reset_mid_request();
    do_reset();
    tick();
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0h exp=1", imem_req); end
    rst = 1'b1; imem_ack = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL mid_reset got=%0h/%0h exp=0/0", imem_req, instr_valid); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin failures++; $display("FAIL late_ack got=%0h/%h/%0h exp=1/0/0", imem_req, imem_addr, instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("FAIL mid_restart got=%0h/%h exp=1/0", instr_valid, instr_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0; imem_ack = 1'b1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pre got=%0h/%h exp=1/fffffffc", imem_req, imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h0 || instr_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr got=%h/%h exp=0/fffffffc", imem_addr, instr_pc); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("FAIL wrap_next got=%0h/%h exp=1/0", instr_valid, instr_pc); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, p_addr, p_pc, tgt;
    logic        p_req, p_valid, drain, dnext;
    int          deliveries;
    do_reset();
    tick();
    exp_pc = 32'h0; drain = 1'b0; deliveries = 0;
    for (int i = 0; i < 1500; i++) begin
      imem_ack = ($urandom_range(0, 9) < 7);
      stall    = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 19) == 0);
      tgt = $urandom() & 32'h0000_0FFF;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
      redirect_pc = tgt;
      p_req = imem_req; p_addr = imem_addr; p_valid = instr_valid; p_pc = instr_pc;
      dnext = redirect_valid ? (p_req && (drain || !imem_ack)) : (drain && !(p_req && imem_ack));
      tick();
      checks++; if (imem_addr[1:0] !== 2'b00) begin failures++; $display("FAIL rnd_align cyc=%0d got=%h", i, imem_addr); end
      checks++; if (!imem_req && !instr_valid) begin failures++; $display("FAIL rnd_idle cyc=%0d got=req0/valid0 exp=activity", i); end
      if (p_req && !imem_ack) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== p_addr) begin failures++; $display("FAIL rnd_stable cyc=%0d got=%0h/%h exp=1/%h", i, imem_req, imem_addr, p_addr); end
      end
      if (redirect_valid) begin
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL rnd_flush cyc=%0d got=%0h exp=0", i, instr_valid); end
        if (!dnext) begin
          checks++;
          if (imem_req !== 1'b1 || imem_addr !== (tgt & 32'hFFFF_FFFC)) begin failures++; $display("FAIL rnd_redir_req cyc=%0d got=%0h/%h exp=1/%h", i, imem_req, imem_addr, tgt & 32'hFFFF_FFFC); end
        end
        exp_pc = tgt & 32'hFFFF_FFFC;
      end else begin
        if (p_valid && stall) begin
          checks++;
          if (instr_valid !== 1'b1 || instr_pc !== p_pc) begin failures++; $display("FAIL rnd_hold cyc=%0d got=%0h/%h exp=1/%h", i, instr_valid, instr_pc, p_pc); end
        end
        if (p_valid && !stall) begin
          exp_pc = exp_pc + 32'd4;
          deliveries++;
        end
        if (p_req && imem_ack && drain) begin
          checks++;
          if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_pc) begin failures++; $display("FAIL rnd_drain cyc=%0d got=%0h/%0h/%h exp=0/1/%h", i, instr_valid, imem_req, imem_addr, exp_pc); end
        end
        if (p_req && imem_ack && !drain && (!p_valid || !stall)) begin
          checks++;
          if (instr_valid !== 1'b1 || instr_pc !== p_addr) begin failures++; $display("FAIL rnd_latency cyc=%0d got=%0h/%h exp=1/%h", i, instr_valid, instr_pc, p_addr); end
        end
        if (p_req && imem_ack && !drain && p_valid && stall) begin
          checks++;
          if (imem_req !== 1'b0) begin failures++; $display("FAIL rnd_skid cyc=%0d got=%0h exp=0", i, imem_req); end
        end
      end
      if (instr_valid) begin
        checks++;
        if (instr_pc !== exp_pc || instr !== word_at(exp_pc)) begin failures++; $display("FAIL rnd_stream cyc=%0d got=%h/%h exp=%h/%h", i, instr_pc, instr, exp_pc, word_at(exp_pc)); end
      end
      drain = dnext;
    end
    redirect_valid = 1'b0;
    checks++; if (deliveries < 100) begin failures++; $display("FAIL rnd_progress got=%0d exp>=100", deliveries); end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_stall();
    test_redirect_drain();
    test_redirect_on_xfer();
    test_reset_mid_request();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the MIPS instruction-fetch path: owns the program counter, issues word requests to instruction memory over a req/ack handshake, and presents fetched instructions to decode with stall backpressure. Sits between the instruction memory and the decode stage. Branch/jump resolution redirects fetch through a single-cycle redirect strobe.

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  request word address, bits [1:0] always 0.
- imem_ack  in  1  memory accepts the request and returns data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_req && imem_ack.
- stall  in  1  decode cannot accept; holds current output.
- redirect_valid  in  1  one-cycle strobe: resume fetch at redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] are forced to 0.
- instr_valid  out  1  instr/instr_pc hold a live instruction.
- instr  out  32  fetched instruction.
- instr_pc  out  32  address of instr.

## Operation
- Registers: pc (next fetch address), req_addr (drives imem_addr), output slot (instr, instr_pc, instr_valid), one-entry skid (word, address, flag).
- Transfer: completes in any cycle where imem_req && imem_ack. imem_ack while imem_req=0 is ignored. req_addr is stable while imem_req=1 until the transfer completes.
- Output slot is consumed in a cycle with instr_valid && !stall. Slot is free if instr_valid=0 or it is consumed that cycle.
- IDLE (reset state): imem_req=0. Next cycle goes to REQ with req_addr=pc.
- REQ: imem_req=1.
  - On transfer with slot free: load slot, pc += 4, req_addr = new pc, stay in REQ.
  - On transfer with slot busy: write word into skid, pc += 4, go to SKID.
- SKID: imem_req=0. When the slot frees, move skid into slot, set req_addr=pc, go to REQ.
- DRAIN: imem_req=1 at the old req_addr. On transfer, discard data, set req_addr=pc, go to REQ.
- Redirect (highest priority after rst): clear instr_valid and skid flag, pc <= {redirect_pc[31:2],2'b00}.
  - REQ without transfer this cycle -> DRAIN (the memory request cannot be aborted).
  - REQ with transfer this cycle -> data discarded, REQ at new pc.
  - SKID or IDLE -> REQ at new pc.
  - DRAIN -> stay in DRAIN with pc updated.
  - A redirect while stalled still flushes the slot.
- pc arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- State encoding: 2 bits {IDLE, REQ, SKID, DRAIN}.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, pc=RESET_PC, skid empty, state IDLE.
- rst overrides everything, including an outstanding request. imem_req=0 on the cycle after rst is sampled.
- First request: imem_req rises on the 2nd cycle after rst deasserts (IDLE lasts one cycle).
- Latency: a transfer at edge N gives instr_valid=1 with that word after edge N, i.e. in cycle N+1.
- Throughput: with imem_ack=1 and stall=0, one instruction per cycle and imem_req stays high.
- Redirect at edge N: instr_valid=0 from N+1. If no drain is needed, a request at the new pc appears at N+1.

## Test plan
- Reset, imem_ack=1, rdata=addr^32'hA5A5_A5A5, stall=0 -> imem_req high in 2nd cycle after reset; instr_pc sequence 0x0, 0x4, 0x8 on consecutive cycles; instr matches.
- Steady fetch, assert stall for 3 cycles while ack=1 -> slot holds 0x0. Word 0x4 goes into skid, imem_req drops. Stall release -> 0x4 presented next cycle, then request 0x8.
- Request 0x8 outstanding with ack=0, redirect to 0x100 -> imem_addr stays 0x8 until ack, and that data never appears. Next request is 0x100; first valid instr_pc is 0x100.
- redirect_pc=0x103 in the same cycle as a transfer of 0xC -> the 0xC word is dropped; next request is 0x100.
- rst pulsed mid-request with ack arriving the next cycle -> imem_req=0 and instr_valid=0 after reset; late ack ignored; fetch restarts at RESET_PC.
- pc at 0xFFFF_FFFC -> next request address is 0x0000_0000.
